// File: rtl/mul32_seq_pkg.sv
// Shared types and widths for the sequential 2*HALF_W x 2*HALF_W multiplier.
// Build option MUL32_SEQ_SIGNED_EN (see mul32_seq.sv) does not change this package.
package mul32_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFin
  } state_e;

  // Port widths of the downstream 18x18 multiplier.
  localparam int unsigned SubOpW   = 18;
  localparam int unsigned SubProdW = 36;

endpackage

// File: rtl/mul32_seq_if.sv
// Handshake to the downstream 18x18 sub-multiplier; master issues operands, slave returns product.
// Build option MUL32_SEQ_SIGNED_EN (see mul32_seq.sv) does not change this interface.
interface mul32_seq_if;
  import mul32_seq_pkg::*;

  logic                mul_start;
  logic [SubOpW-1:0]   mul_a;
  logic [SubOpW-1:0]   mul_b;
  logic                mul_done;
  logic [SubProdW-1:0] mul_p;

  modport master (output mul_start, mul_a, mul_b, input mul_done, mul_p);
  modport slave  (input mul_start, mul_a, mul_b, output mul_done, mul_p);

endinterface

// File: rtl/mul32_seq_acc.sv
// Shift-and-add accumulator: adds a sub-product shifted by 0, HALF_W or 2*HALF_W.
// Build option MUL32_SEQ_SIGNED_EN (see mul32_seq.sv) does not change this block.
module mul32_seq_acc
  import mul32_seq_pkg::*;
#(
  parameter int unsigned HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [1:0]            sel_i,
  input  logic [SubProdW-1:0]   prod_i,
  output logic [4*HALF_W-1:0]   acc_o
);

  localparam int unsigned AccW = 4 * HALF_W;

  logic [AccW-1:0] acc_q, acc_d, addend;

  // The size cast zero-extends or truncates; the sum wraps modulo 2^AccW.
  always_comb begin
    unique case (sel_i)
      2'd0:       addend = AccW'(prod_i);
      2'd1, 2'd2: addend = AccW'(prod_i) << HALF_W;
      default:    addend = AccW'(prod_i) << (2 * HALF_W);
    endcase
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + addend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul32_seq.sv
// Sequential multiplier: four half-width partials on an external 18x18 multiplier, accumulated.
// Define MUL32_SEQ_SIGNED_EN for two's-complement operands (sign applied at FIN, no extra cycle).
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int unsigned HALF_W   = 16,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2*HALF_W-1:0]   a_i,
  input  logic [2*HALF_W-1:0]   b_i,
  mul32_seq_if.master           mul_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [4*HALF_W-1:0]   p_o
);

  localparam int unsigned OpW  = 2 * HALF_W;
  localparam int unsigned AccW = 4 * HALF_W;
  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic [OpW-1:0]  a_q, a_d, b_q, b_d;
  logic [AccW-1:0] p_q, p_d;
  logic            done_q, done_d, err_q, err_d;
  logic            acc_clr, acc_add;
  logic [AccW-1:0] acc;
  logic [OpW-1:0]  a_op, b_op;
  logic [AccW-1:0] res;

`ifdef MUL32_SEQ_SIGNED_EN
  logic neg_q, neg_d;

  // Unsigned magnitudes; the most-negative value maps onto its own bit pattern.
  assign a_op = a_i[OpW-1] ? -a_i : a_i;
  assign b_op = b_i[OpW-1] ? -b_i : b_i;
  assign res  = neg_q ? -acc : acc;

  always_comb begin
    neg_d = neg_q;
    if (state_q == StIdle && start_i) begin
      neg_d = a_i[OpW-1] ^ b_i[OpW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  assign a_op = a_i;
  assign b_op = b_i;
  assign res  = acc;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_op;
          b_d     = b_op;
          idx_d   = 2'd0;
          acc_clr = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mul_if.mul_done) begin
          acc_add = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StIssue;
          end
        end else if (wcnt_q == CntW'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_q + CntW'(1);
        end
      end
      StFin: begin
        p_d     = res;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mul32_seq_acc #(
    .HALF_W (HALF_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .sel_i  (idx_q),
    .prod_i (mul_if.mul_p),
    .acc_o  (acc)
  );

  // Partial order lo*lo, lo*hi, hi*lo, hi*hi: idx[1] picks the a half, idx[0] the b half.
  assign mul_if.mul_start = (state_q == StIssue);
  assign mul_if.mul_a     = SubOpW'(idx_q[1] ? a_q[OpW-1:HALF_W] : a_q[HALF_W-1:0]);
  assign mul_if.mul_b     = SubOpW'(idx_q[0] ? b_q[OpW-1:HALF_W] : b_q[HALF_W-1:0]);

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign err_o  = err_q;
  assign p_o    = p_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: behavioural product/timing model, sub-multiplier responder, directed vectors.
// Signed vectors are selected when MUL32_SEQ_SIGNED_EN is defined.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, err;
  logic [63:0] p;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          ms_cnt = 0;
  int          lat_n  = 3;
  bit          withhold = 1'b0;
  bit          chk_en   = 1'b1;

  mul32_seq_if mif ();

  mul32_seq #(
    .HALF_W   (16),
    .WAIT_MAX (255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .mul_if  (mif.master),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .p_o     (p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mif.mul_start) ms_cnt <= ms_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL32_SEQ_SIGNED_EN
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    model = 64'(sx * sy);
`else
    longint unsigned ux, uy;
    ux = x;
    uy = y;
    model = ux * uy;
`endif
  endfunction

  // Ideal sub-multiplier: answers lat_n cycles after each mul_start.
  initial begin
    logic [17:0] ca, cb;
    mif.mul_done = 1'b0;
    mif.mul_p    = '0;
    forever begin
      @(negedge clk);
      mif.mul_done = 1'b0;
      if (mif.mul_start && !rst && !withhold) begin
        ca = mif.mul_a;
        cb = mif.mul_b;
        repeat (lat_n) begin
          @(negedge clk);
          if (busy) begin
            chk("mul_a held", 64'(mif.mul_a), 64'(ca));
            chk("mul_b held", 64'(mif.mul_b), 64'(cb));
          end
        end
        mif.mul_done = 1'b1;
        mif.mul_p    = {18'b0, ca} * {18'b0, cb};
      end
    end
  end

  // Model: busy for L cycles after the accepting edge, done and new p at exactly L.
  initial begin
    bit          m_active = 1'b0;
    int          m_s = 0, m_L = 0, r;
    logic [63:0] m_exp = '0, m_p = '0;
    bit          exp_busy, exp_done;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_p      = '0;
      end else if (!chk_en) begin
        m_active = 1'b0;
      end else begin
        r        = cyc - m_s;
        exp_busy = m_active && (r < m_L);
        exp_done = m_active && (r == m_L);
        if (exp_done) m_p = m_exp;
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        chk("err", 64'(err), 64'd0);
        if (!exp_busy) chk("p", p, m_p);
        if (exp_done) m_active = 1'b0;
        if (start && !exp_busy) begin
          m_active = 1'b1;
          m_s      = cyc + 1;
          m_L      = 4 * (lat_n + 1) + 1;
          m_exp    = model(a, b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int s, output logic [63:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - s;
        res = p;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int n,
                        output logic [63:0] res, output int lat);
    int s;
    lat_n = n;
    a     = x;
    b     = y;
    start = 1'b1;
    s     = cyc + 1;
    tick();
    start = 1'b0;
    wait_done(s, res, lat);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " p"}, p, 64'd0);
    chk({tag, " mul_start"}, 64'(mif.mul_start), 64'd0);
    chk({tag, " mul_a"}, 64'(mif.mul_a), 64'd0);
    chk({tag, " mul_b"}, 64'(mif.mul_b), 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    int          lat, ms0, errs, dseen, s1, s2;
    bit          dropped;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    ms0 = ms_cnt;
    run_op(32'h0000FFFF, 32'h0000FFFF, 3, res, lat);
    chk("ffff^2 p", res, 64'h00000000FFFE0001);
    chk("ffff^2 latency", 64'(lat), 64'd17);
    chk("ffff^2 mul_start pulses", 64'(ms_cnt - ms0), 64'd4);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, res, lat);
`ifdef MUL32_SEQ_SIGNED_EN
    chk("-1*-1 p", res, 64'h0000000000000001);
`else
    chk("max^2 p", res, 64'hFFFFFFFE00000001);
`endif
    chk("N=1 latency", 64'(lat), 64'd9);

    ms0 = ms_cnt;
    run_op(32'h00000000, 32'h1234ABCD, 2, res, lat);
    chk("zero operand p", res, 64'd0);
    chk("zero operand pulses", 64'(ms_cnt - ms0), 64'd4);
    chk("N=2 latency", 64'(lat), 64'd13);

    run_op(32'h80000000, 32'h80000000, 2, res, lat);
    chk("2^31 squared p", res, 64'h4000000000000000);
`ifdef MUL32_SEQ_SIGNED_EN
    run_op(32'hFFFFFFFE, 32'h00000003, 3, res, lat);
    chk("-2*3 p", res, 64'hFFFFFFFFFFFFFFFA);
    run_op(32'h00000007, 32'hFFFFFFF9, 1, res, lat);
    chk("7*-7 p", res, 64'hFFFFFFFFFFFFFFCF);
`endif
    run_op(32'h12345678, 32'h9ABCDEF0, 4, res, lat);
    run_op(32'h00000003, 32'h00000005, 1, res, lat);
    chk("3*5 p", res, 64'd15);

    // Withheld sub-product: abort with err, p keeps 15.
    chk_en   = 1'b0;
    withhold = 1'b1;
    a        = 32'h0000AAAA;
    b        = 32'h00005555;
    start    = 1'b1;
    tick();
    start   = 1'b0;
    errs    = 0;
    dseen   = 0;
    dropped = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) errs++;
      if (done) dseen++;
      if (!busy) begin
        dropped = 1'b1;
        break;
      end
    end
    chk("timeout busy dropped", 64'(dropped), 64'd1);
    repeat (2) begin
      @(negedge clk);
      if (err) errs++;
      if (done) dseen++;
    end
    chk("timeout err pulses", 64'(errs), 64'd1);
    chk("timeout no done", 64'(dseen), 64'd0);
    chk("timeout p kept", p, 64'd15);
    tick();
    withhold = 1'b0;
    chk_en   = 1'b1;
    run_op(32'h00000007, 32'h00000009, 1, res, lat);
    chk("after timeout p", res, 64'd63);

    // Reset during the second WAIT; the pending sub-product arrives afterwards.
    lat_n = 3;
    a     = 32'h11111111;
    b     = 32'h22222222;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid-op busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    dseen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("stale mul_done no done", 64'(dseen), 64'd0);
    check_zero("post-reset");
    tick();
    run_op(32'h00000003, 32'h00000005, 2, res, lat);
    chk("post-reset 3*5 p", res, 64'd15);

    // Start held across done, then a stray start while busy.
    lat_n = 1;
    a     = 32'h00000010;
    b     = 32'h00000020;
    start = 1'b1;
    s1    = cyc + 1;
    tick();
    a = 32'h00001000;
    b = 32'h00000003;
    wait_done(s1, res, lat);
    chk("b2b first p", res, 64'h200);
    s2 = cyc + 1;
    tick();
    start = 1'b0;
    tick();
    a     = 32'h0000FFFF;
    b     = 32'h0000FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(s2, res, lat);
    chk("b2b second p", res, 64'h3000);
    chk("b2b second latency", 64'(lat), 64'd9);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
